// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          CNT_W            = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: redirect, instruction memory port, decode handshake.
interface fetch_queue_if;

  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_instr_ready;
  logic        o_fetch_misalign;
  logic [31:0] o_misalign_pc;

  modport master (
    input  i_redirect_valid, i_redirect_pc, i_imem_ready, i_imem_rvalid,
           i_imem_rdata, i_instr_ready,
    output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc,
           o_fetch_misalign, o_misalign_pc
  );

  modport slave (
    output i_redirect_valid, i_redirect_pc, i_imem_ready, i_imem_rvalid,
           i_imem_rdata, i_instr_ready,
    input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc,
           o_fetch_misalign, o_misalign_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear dominates push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, credits imem requests, drops stale
// responses after a redirect. FETCH_MISALIGN_CHECK_EN enables misaligned-redirect halting.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_OUT  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] o_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] live;
  logic [FW-1:0]    fill;
  logic             halted;
  logic [31:0]      redir_pc;
  logic             redirect;
  logic             rvalid;
  logic             accept;
  logic             credit_ok;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  assign redirect = bus.i_redirect_valid;
  assign rvalid   = bus.i_imem_rvalid;

  // Queue entries plus live in-flight requests may never exceed the queue size.
  assign live      = o_cnt - drop_cnt;
  assign fill      = {1'b0, live} + FW'(fifo_count);
  assign credit_ok = (fill < FW'(DEPTH)) & ~fifo_full;

  assign bus.o_imem_req  = i_rst_n & ~redirect & ~halted & credit_ok &
                           (o_cnt < CNT_W'(MAX_OUT));
  assign bus.o_imem_addr = fetch_pc;
  assign accept          = bus.o_imem_req & bus.i_imem_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        redir_bad;
  logic        mis_q;
  logic [31:0] mis_pc_q;

  assign redir_pc  = bus.i_redirect_pc;
  assign redir_bad = (bus.i_redirect_pc[1:0] != 2'b00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halted   <= 1'b0;
      mis_q    <= 1'b0;
      mis_pc_q <= '0;
    end else begin
      mis_q <= redirect & redir_bad;
      if (redirect) halted <= redir_bad;
      if (redirect && redir_bad) mis_pc_q <= bus.i_redirect_pc;
    end
  end

  assign bus.o_fetch_misalign = mis_q;
  assign bus.o_misalign_pc    = mis_pc_q;
`else
  assign redir_pc             = word_align(bus.i_redirect_pc);
  assign halted               = 1'b0;
  assign bus.o_fetch_misalign = 1'b0;
  assign bus.o_misalign_pc    = '0;
`endif

  // A redirect dooms every response still owed, minus the one arriving this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      o_cnt    <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redir_pc;
      resp_pc  <= redir_pc;
      o_cnt    <= o_cnt - CNT_W'(rvalid);
      drop_cnt <= o_cnt - CNT_W'(rvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      o_cnt <= o_cnt + CNT_W'(accept) - CNT_W'(rvalid);
      if (rvalid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else                resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  assign push_entry = '{pc: resp_pc, instr: bus.i_imem_rdata};
  assign fifo_push  = rvalid & (drop_cnt == '0) & ~redirect;
  assign fifo_pop   = bus.i_instr_ready & ~redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.o_instr_valid = ~fifo_empty;
  assign bus.o_instr       = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign bus.o_pc          = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order imem model plus a scoreboard of expected fetches.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .MAX_OUT(MAX_OUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct { logic [31:0] data; int due; } mem_rsp_t;
  typedef struct { logic [31:0] target; int lat; int ticks; logic [31:0] exp_pc; int exp_delay; } vec_t;

  mem_rsp_t     memq[$];
  fetch_entry_t sb[$];
  logic [31:0]  acc_log[$];

  int          checks, errors, cyc, lat, accepts;
  int          first_acc_tick, first_valid_tick;
  logic        mem_ready, exp_halted, mis_pending, have_pop;
  logic [31:0] exp_fetch_pc, exp_mis_pc, first_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic markWindow();
    first_acc_tick   = -1;
    first_valid_tick = -1;
    have_pop         = 1'b0;
    accepts          = 0;
    acc_log.delete();
  endtask

  // Compares the DUT against the bench model for the current cycle, then updates the model.
  task automatic checkOutput(input logic redir, input logic [31:0] rpc, input logic dready,
                             input int out_before, input int live_before);
    logic         exp_req;
    fetch_entry_t e;
    exp_req = !redir && !exp_halted && (live_before < DEPTH) && (out_before < MAX_OUT);
    check32("imem_req", {31'b0, bus.o_imem_req}, {31'b0, exp_req});
    if (bus.o_imem_req) check32("imem_addr", bus.o_imem_addr, exp_fetch_pc);
    check32("misalign", {31'b0, bus.o_fetch_misalign}, {31'b0, mis_pending});
    check32("misalign_pc", bus.o_misalign_pc, exp_mis_pc);
    if (!bus.o_instr_valid) begin
      check32("empty_instr", bus.o_instr, NOP_INSTR);
      check32("empty_pc", bus.o_pc, 32'h0);
    end else if (first_valid_tick < 0) first_valid_tick = cyc;
    if (bus.o_imem_req && mem_ready) begin
      memq.push_back('{data: mem_word(bus.o_imem_addr), due: cyc + lat});
      e.pc    = exp_fetch_pc;
      e.instr = mem_word(exp_fetch_pc);
      sb.push_back(e);
      acc_log.push_back(bus.o_imem_addr);
      accepts++;
      if (first_acc_tick < 0) first_acc_tick = cyc;
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    mis_pending = 1'b0;
    if (redir) begin
      sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_fetch_pc = rpc;
      exp_halted   = (rpc[1:0] != 2'b00);
      if (exp_halted) begin
        mis_pending = 1'b1;
        exp_mis_pc  = rpc;
      end
`else
      exp_fetch_pc = {rpc[31:2], 2'b00};
`endif
    end else if (bus.o_instr_valid && dready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_unexpected actual_pc=%h required=no_valid", bus.o_pc);
      end else begin
        e = sb.pop_front();
        check32("pop_pc", bus.o_pc, e.pc);
        check32("pop_instr", bus.o_instr, e.instr);
      end
      if (!have_pop) begin
        have_pop     = 1'b1;
        first_pop_pc = bus.o_pc;
      end
    end
  endtask

  // Drives one clock cycle of stimulus starting just after a falling edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic dready);
    int out_before;
    int live_before;
    out_before  = memq.size();
    live_before = sb.size();
    bus.i_redirect_valid = redir;
    bus.i_redirect_pc    = rpc;
    bus.i_instr_ready    = dready;
    bus.i_imem_ready     = mem_ready;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = memq[0].data;
      void'(memq.pop_front());
    end else begin
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = '0;
    end
    #1;
    checkOutput(redir, rpc, dready, out_before, live_before);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_imem_ready     = 1'b0;
    bus.i_imem_rvalid    = 1'b0;
    bus.i_imem_rdata     = '0;
    bus.i_instr_ready    = 1'b0;
    memq.delete();
    sb.delete();
    exp_fetch_pc = 32'h0;
    exp_halted   = 1'b0;
    mis_pending  = 1'b0;
    exp_mis_pc   = 32'h0;
    #2;
    check32("rst_req", {31'b0, bus.o_imem_req}, 32'h0);
    check32("rst_valid", {31'b0, bus.o_instr_valid}, 32'h0);
    check32("rst_instr", bus.o_instr, NOP_INSTR);
    check32("rst_pc", bus.o_pc, 32'h0);
    check32("rst_misalign", {31'b0, bus.o_fetch_misalign}, 32'h0);
    check32("rst_misalign_pc", bus.o_misalign_pc, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 20 && memq.size() > 0; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checks++;
    if (memq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", memq.size());
    end
    mem_ready = 1'b1;
  endtask

  task automatic checkFirstPop(input string name, input logic [31:0] exp);
    if (!have_pop) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=none expected=%h", name, exp);
    end else check32(name, first_pop_pc, exp);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [31:0] ra;
    int          t0, mis_count;
    logic        found;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    lat       = 1;
    mem_ready = 1'b1;

    vecs[0] = '{32'h0000_1000, 1, 10, 32'h0000_1000, 3};
    vecs[1] = '{32'h0000_2040, 2, 12, 32'h0000_2040, 4};
    vecs[2] = '{32'h8000_0000, 3, 14, 32'h8000_0000, 5};
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs[3] = '{32'h0000_3000, 1, 10, 32'h0000_3000, 3};
`else
    vecs[3] = '{32'h0000_3003, 1, 10, 32'h0000_3000, 3};
`endif

    doReset();

    markWindow();
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1);
    if (acc_log.size() < 3) begin
      checks++;
      errors++;
      $display("[TB] FAIL boot_requests actual=%0d required=3", acc_log.size());
    end else begin
      check32("boot_addr0", acc_log[0], 32'h0);
      check32("boot_addr1", acc_log[1], 32'h4);
      check32("boot_addr2", acc_log[2], 32'h8);
    end
    check32("boot_latency", first_valid_tick - first_acc_tick, 32'd2);
    checkFirstPop("boot_first_pc", 32'h0);

    foreach (vecs[k]) begin
      drain();
      lat = vecs[k].lat;
      t0  = cyc;
      applyStimulus(1'b1, vecs[k].target, 1'b1);
      markWindow();
      repeat (vecs[k].ticks) applyStimulus(1'b0, 32'h0, 1'b1);
      check32("vec_first_pc", first_pop_pc, vecs[k].exp_pc);
      check32("vec_delay", first_valid_tick - t0, vecs[k].exp_delay);
    end

    // Decode stalled: queue fills, then one pop frees exactly one request.
    drain();
    lat = 1;
    applyStimulus(1'b1, 32'h500, 1'b0);
    markWindow();
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    check32("stall_accepts", accepts, DEPTH);
    check32("stall_req_low", {31'b0, bus.o_imem_req}, 32'h0);
    markWindow();
    t0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    check32("stall_resume_accepts", accepts, 32'd1);
    check32("stall_resume_tick", first_acc_tick - t0, 32'd1);

    // Redirect with slow responses in flight; stale data must be dropped.
    drain();
    lat = 3;
    applyStimulus(1'b1, 32'h40, 1'b1);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
    t0 = cyc;
    applyStimulus(1'b1, 32'h100, 1'b1);
    markWindow();
    repeat (14) applyStimulus(1'b0, 32'h0, 1'b1);
    checkFirstPop("flush_first_pc", 32'h100);
    check32("flush_delay", first_valid_tick - t0, 32'd5);

    // Redirect coinciding with a response and a pop.
    drain();
    lat = 1;
    applyStimulus(1'b1, 32'h300, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && bus.o_instr_valid) found = 1'b1;
      else applyStimulus(1'b0, 32'h0, 1'b1);
    end
    check32("collide_found", {31'b0, found}, 32'h1);
    applyStimulus(1'b1, 32'h400, 1'b1);
    check32("collide_empty", {31'b0, bus.o_instr_valid}, 32'h0);
    markWindow();
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkFirstPop("collide_first_pc", 32'h400);

    // Address wrap at the top of memory.
    drain();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    markWindow();
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
    if (acc_log.size() < 2) begin
      checks++;
      errors++;
      $display("[TB] FAIL wrap_requests actual=%0d required=2", acc_log.size());
    end else begin
      check32("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      check32("wrap_addr1", acc_log[1], 32'h0000_0000);
    end

    // Random traffic with stalls and occasional redirects, then a mid-run reset.
    drain();
    lat = 2;
    for (int i = 0; i < 150; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      ra = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(($urandom_range(0, 19) == 0), ra, $urandom_range(0, 1) == 1);
    end
    mem_ready = 1'b1;
    doReset();
    lat = 1;
    markWindow();
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkFirstPop("reset_first_pc", 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    drain();
    applyStimulus(1'b1, 32'h102, 1'b1);
    markWindow();
    mis_count = 0;
    repeat (6) begin
      if (bus.o_fetch_misalign) mis_count++;
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    check32("mis_pulses", mis_count, 32'd1);
    check32("mis_accepts", accepts, 32'd0);
    check32("mis_pc_hold", bus.o_misalign_pc, 32'h102);
    applyStimulus(1'b1, 32'h200, 1'b1);
    markWindow();
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkFirstPop("mis_resume_pc", 32'h200);
`else
    mis_count = 0;
    drain();
    applyStimulus(1'b1, 32'h102, 1'b1);
    markWindow();
    repeat (6) begin
      if (bus.o_fetch_misalign) mis_count++;
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    check32("nomis_pulses", mis_count, 32'd0);
    checkFirstPop("nomis_first_pc", 32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
